// File: rtl/fpu_pkg.sv
// Shared single-precision field definitions used across the FPU blocks.
package fpu_pkg;

  localparam int FP_W     = 32;
  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;

  // Bit positions of each field inside a packed single.
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_LSB = 0;

endpackage

// File: rtl/lzc32.sv
// 32-bit leading-zero counter; cnt is 32 and zero is set for an all-zero input.
module lzc32 (
  input  logic [31:0] a,
  output logic [5:0]  cnt,
  output logic        zero
);

  // Ascending scan so the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) cnt = 6'(31 - i);
    end
  end

  assign zero = ~|a;

endmodule

// File: rtl/itof.sv
// Two-stage int32 -> IEEE-754 single converter, round-to-nearest-even.
// S1 holds sign/magnitude/leading-zero count, S2 holds the packed result.
module itof
  import fpu_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic [FP_W-1:0] x,
  input  logic            x_valid,
  output logic            x_ready,
  output logic [FP_W-1:0] y,
  output logic            y_valid,
  input  logic            y_ready
);

  // Handshake: a word moves on a rising edge only when its valid and ready
  // are both high; y/y_valid hold while stalled, and x_ready never looks at x_valid.
  logic              v1, v2;
  logic              s1_sign, s1_zero;
  logic [FP_W-1:0]   s1_mag;
  logic [5:0]        s1_lzc;
  logic [FP_W-1:0]   y_q;

  logic              ld1, ld2;
  logic [FP_W-1:0]   mag_d;
  logic [5:0]        lzc_d;
  logic              zero_d;

  assign x_ready = ~v1 | (~v2 | y_ready);
  assign ld1     = x_valid & x_ready;
  assign ld2     = v1 & (~v2 | y_ready);

  assign mag_d = x[SIGN_BIT] ? (~x + 32'd1) : x;

  lzc32 u_lzc (
    .a    (mag_d),
    .cnt  (lzc_d),
    .zero (zero_d)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_mag  <= '0;
      s1_lzc  <= '0;
    end else begin
      v1 <= ld1 | (v1 & ~ld2);
      if (ld1) begin
        s1_sign <= x[SIGN_BIT];
        s1_zero <= zero_d;
        s1_mag  <= mag_d;
        s1_lzc  <= lzc_d;
      end
    end
  end

  // Normalise so the leading one falls off the top; what remains is frac|guard|sticky.
  logic [30:0]       norm;
  logic              guard, sticky, lsb, rnd_up, carry;
  logic [23:0]       frac_sum;
  logic [EXP_W-1:0]  exp_pre, exp_fin;
  logic [FRAC_W-1:0] frac_fin;
  logic [FP_W-1:0]   y_d;

  assign norm     = 31'(s1_mag << s1_lzc);
  assign lsb      = norm[8];
  assign guard    = norm[7];
  assign sticky   = |norm[6:0];
  assign rnd_up   = guard & (sticky | lsb);
  assign frac_sum = {1'b0, norm[30:8]} + 24'(rnd_up);
  assign carry    = frac_sum[23];
  assign exp_pre  = 8'(EXP_BIAS + 31) - {2'b00, s1_lzc};
  assign exp_fin  = exp_pre + 8'(carry);
  assign frac_fin = frac_sum[FRAC_W-1:0];

  always_comb begin
    y_d = '0;
    if (!s1_zero) begin
      y_d[SIGN_BIT]          = s1_sign;
      y_d[EXP_MSB:EXP_LSB]   = exp_fin;
      y_d[FRAC_MSB:FRAC_LSB] = frac_fin;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2  <= 1'b0;
      y_q <= '0;
    end else begin
      v2 <= ld2 | (v2 & ~y_ready);
      if (ld2) y_q <= y_d;
    end
  end

  assign y       = y_q;
  assign y_valid = v2;

endmodule

// File: doc/itof.md
ITOF -- requirements
Module: itof

Interface
REQ-001 The block SHALL have no parameters; latency and rounding mode are fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 x  input  32  two's-complement signed integer operand.
REQ-005 x_valid  input  1  operand valid.
REQ-006 x_ready  output  1  block can accept an operand this cycle.
REQ-007 y  output  32  IEEE-754 single result, {sign, exp[7:0], frac[22:0]}.
REQ-008 y_valid  output  1  result valid.
REQ-009 y_ready  input  1  consumer accepts result this cycle.

Function
REQ-010 Transfers SHALL occur on each side only when valid and ready are both high at a rising edge.
REQ-011 y SHALL equal x converted to single precision with round-to-nearest, ties-to-even.
REQ-012 x = 0 SHALL give y = 0x00000000; no negative zero is ever produced.
REQ-013 Sign: y[31] = x[31]; magnitude = |x| computed in 32 bits unsigned, so x = 0x80000000 SHALL give magnitude 2^31.
REQ-014 With leading-one position p (0..31) of the magnitude, the exponent SHALL be 127+p before rounding.
REQ-015 For p <= 23 the conversion SHALL be exact, with frac = magnitude shifted left by 23-p, hidden bit dropped.
REQ-016 For p > 23: guard is bit p-24, sticky is the OR of bits below it, and lsb is bit p-23; the result SHALL round up iff guard & (sticky | lsb).
REQ-017 A mantissa carry-out from rounding SHALL increment the exponent and clear frac; the exponent never exceeds 158, so no overflow or infinity path exists.
REQ-018 Pipeline SHALL be two register stages; S1 holds sign, magnitude and leading-zero count; S2 holds the packed result driving y.
REQ-019 Latency SHALL be 2 cycles from x acceptance to y_valid when unstalled; throughput SHALL be one result per cycle.
REQ-020 Each stage SHALL have a valid bit; a stage loads when it is empty or its content is leaving in the same cycle.
REQ-021 x_ready SHALL be ~v1 | (~v2 | y_ready), with no combinational path from x_valid to x_ready.
REQ-022 While y_valid & ~y_ready, y and y_valid SHALL hold stable.
REQ-023 Results SHALL leave in acceptance order, with no loss or duplication; at most 2 results are in flight.
REQ-024 Simultaneous accept and emit in a full pipeline SHALL shift both stages in one cycle.

Reset
REQ-025 On rstn low, v1, v2, y_valid and all data registers SHALL clear to 0 immediately; y = 0x00000000 and x_ready = 1 in the first cycle after release.
REQ-026 Reset mid-operation SHALL discard in-flight operands; no stale result may appear after release.

Structure
REQ-027 The shared package fpu_pkg SHALL hold EXP_BIAS = 127, the field widths (1/8/23) and the field slice constants; the existing FPU blocks share this package.
REQ-028 Leading-zero counting SHALL be a sub-module lzc32 (32-bit input, 6-bit count, all-zero flag), instantiated once in S1.

Verification
REQ-029 Basic values, y_ready = 1: x = 1 -> 0x3F800000; x = 0xFFFFFFFF (-1) -> 0xBF800000; x = 0 -> 0x00000000; each appears exactly 2 cycles after acceptance.
REQ-030 Rounding: x = 16777217 -> 0x4B800000 (tie, even); x = 16777219 -> 0x4B800002 (tie, odd rounds up); x = 16777221 -> 0x4B800002.
REQ-031 Extremes: x = 0x7FFFFFFF -> 0x4F000000 (carry-out); x = 0x80000000 -> 0xCF000000; x = 0x00FFFFFF -> 0x4B7FFFFF (exact).
REQ-032 Backpressure: stream 4 operands with y_ready low for 5 cycles -> x_ready drops after 2 accepts, y holds stable, and all 4 results emerge in order once y_ready rises.
REQ-033 Random: 10^6 random x with random valid/ready toggling -> every y matches a reference model bit-exactly, and output count equals accepted count.
REQ-034 Reset mid-flight: assert rstn low asynchronously with 2 results pending -> y_valid falls without a clock edge, and no result emerges after release.
